// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage: upstream valid/data/allowin,
// downstream valid/data/allow, flush and the status outputs.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32
);
    logic              valid_in;
    logic [DATA_W-1:0] data_in;
    logic              allowin_out;
    logic              valid_out;
    logic [DATA_W-1:0] data_out;
    logic              allow_in;
    logic              flush;
    logic [1:0]        occupancy;
    logic [15:0]       stall_cnt;

    // The stage itself
    modport slave (
        input  valid_in, data_in, allow_in, flush,
        output allowin_out, valid_out, data_out, occupancy, stall_cnt
    );

    // Whatever drives the stage and consumes its output
    modport master (
        output valid_in, data_in, allow_in, flush,
        input  allowin_out, valid_out, data_out, occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/allowin handshake.
// SKID=0: one payload register, allowin_out is combinational from allow_in.
// SKID=1: main register plus one skid entry, allowin_out comes from a flop
//         so the allow_in -> allowin_out path is broken.
// Also reports occupancy and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int                DATA_W  = 32,
    parameter int                SKID    = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input logic              clk,
    input logic              rsta,
    pipe_stage_reg_if.slave  bus
);

    logic              valid_reg;
    logic [DATA_W-1:0] data_reg;
    logic              skid_valid;
    logic              allowin;
    logic              in_fire;
    logic              out_fire;
    logic [15:0]       stall_cnt_reg;

    assign in_fire  = bus.valid_in && allowin;
    assign out_fire = valid_reg && bus.allow_in;

    generate
        if (SKID == 0) begin : g_single
            assign allowin    = !valid_reg || bus.allow_in;
            assign skid_valid = 1'b0;

            // Single register: load on accept, drain on downstream take
            always_ff @(posedge clk or posedge rsta) begin
                if (rsta) begin
                    valid_reg <= 1'b0;
                    data_reg  <= RST_VAL;
                end else if (bus.flush) begin
                    valid_reg <= 1'b0;
                end else if (in_fire) begin
                    valid_reg <= 1'b1;
                    data_reg  <= bus.data_in;
                end else if (out_fire) begin
                    valid_reg <= 1'b0;
                end
            end
        end else begin : g_skid
            logic              skid_valid_reg;
            logic [DATA_W-1:0] skid_data_reg;

            // A full skid entry is the only reason to refuse input, so the
            // upstream sees a pure flop output.
            assign allowin    = !skid_valid_reg;
            assign skid_valid = skid_valid_reg;

            // Main register refills from skid first to keep FIFO order;
            // input arriving while main is stuck parks in the skid entry.
            always_ff @(posedge clk or posedge rsta) begin
                if (rsta) begin
                    valid_reg      <= 1'b0;
                    data_reg       <= RST_VAL;
                    skid_valid_reg <= 1'b0;
                    skid_data_reg  <= RST_VAL;
                end else if (bus.flush) begin
                    valid_reg      <= 1'b0;
                    skid_valid_reg <= 1'b0;
                end else if (!valid_reg || out_fire) begin
                    if (skid_valid_reg) begin
                        valid_reg      <= 1'b1;
                        data_reg       <= skid_data_reg;
                        skid_valid_reg <= 1'b0;
                    end else if (in_fire) begin
                        valid_reg <= 1'b1;
                        data_reg  <= bus.data_in;
                    end else begin
                        valid_reg <= 1'b0;
                    end
                end else if (in_fire) begin
                    skid_valid_reg <= 1'b1;
                    skid_data_reg  <= bus.data_in;
                end
            end
        end
    endgenerate

    // Count cycles where output is offered but refused; sticks at all-ones
    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) begin
            stall_cnt_reg <= 16'h0000;
        end else if (valid_reg && !bus.allow_in && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'h0001;
        end
    end

    assign bus.allowin_out = allowin;
    assign bus.valid_out   = valid_reg;
    assign bus.data_out    = data_reg;
    assign bus.occupancy   = {1'b0, valid_reg} + {1'b0, skid_valid};
    assign bus.stall_cnt   = stall_cnt_reg;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width in bits, legal range 1..256.
REQ-002 SHALL have parameter SKID, default 1: 0 = single register with combinational allowin; 1 = two-entry skid buffer with registered allowin.
REQ-003 SHALL have parameter RST_VAL, default 0 (DATA_W bits): reset value of payload registers.
REQ-004 SHALL have one clock; reset is asynchronous and active-high: clk  input  1  rising-edge clock.
REQ-005 SHALL have rsta  input  1  asynchronous active-high reset.
REQ-006 SHALL have valid_in  input  1  upstream payload valid.
REQ-007 SHALL have data_in  input  DATA_W  upstream payload.
REQ-008 SHALL have allowin_out  output  1  this stage accepts data_in this cycle.
REQ-009 SHALL have valid_out  output  1  data_out valid to downstream.
REQ-010 SHALL have data_out  output  DATA_W  registered payload to downstream.
REQ-011 SHALL have allow_in  input  1  downstream accepts this cycle.
REQ-012 SHALL have flush  input  1  synchronous kill of all held entries.
REQ-013 SHALL have occupancy  output  2  entries held (0..1 for SKID=0, 0..2 for SKID=1).
REQ-014 SHALL have stall_cnt  output  16  cycles with valid_out=1 and allow_in=0, saturating.

Function
REQ-015 SHALL define in_fire = valid_in && allowin_out and out_fire = valid_out && allow_in.
REQ-016 SKID=0: allowin_out SHALL equal !valid_out || allow_in, combinationally.
REQ-017 SKID=0: on in_fire, valid_out<=1 and data_out<=data_in next edge; else on out_fire, valid_out<=0; else hold.
REQ-018 SKID=1: allowin_out SHALL be driven only from flops, equal to !skid_valid; no combinational path from allow_in.
REQ-019 SKID=1, main empty or out_fire: main SHALL load from skid entry if skid_valid (skid cleared), else from data_in if in_fire, else valid_out<=0.
REQ-020 SKID=1, main full and no out_fire: in_fire SHALL write data_in into skid entry, skid_valid<=1.
REQ-021 SKID=1, skid_valid, out_fire and in_fire simultaneously: impossible by REQ-018; skid moves to main, skid_valid<=0.
REQ-022 Ordering SHALL be strict FIFO; no payload duplicated or dropped except by flush.
REQ-023 flush SHALL take priority: next edge valid_out<=0, skid_valid<=0; concurrent in_fire discarded; payload registers may keep stale values.
REQ-024 data_out SHALL not change while valid_out=1 and allow_in=0 (no flush).
REQ-025 Latency SHALL be 1 cycle data_in to data_out when stage empty; throughput 1 per cycle with allow_in held high.
REQ-026 occupancy SHALL equal valid_out + skid_valid, updated same edge as those flops.
REQ-027 stall_cnt SHALL increment on each edge where valid_out && !allow_in, saturate at 16'hFFFF, never wrap, unaffected by flush.

Reset
REQ-028 On rsta=1, immediately and independent of clk: valid_out=0, skid_valid=0, data_out=RST_VAL, skid payload=RST_VAL, occupancy=0, stall_cnt=0.
REQ-029 During and after reset allowin_out SHALL be 1 (both modes).
REQ-030 Reset asserted mid-transfer SHALL discard all held entries; first in_fire after release SHALL appear on data_out one cycle later.

Verification
REQ-031 SKID=1, allow_in=1, stream 0x11,0x22,0x33 back-to-back -> data_out 0x11,0x22,0x33 on consecutive cycles, one cycle lag, occupancy 1.
REQ-032 SKID=1, send 0xA1,0xA2 with allow_in=0 -> occupancy 2, allowin_out=0, data_out holds 0xA1; raise allow_in -> 0xA1 then 0xA2, allowin_out=1 one cycle after 0xA1 leaves.
REQ-033 SKID=0, valid_out=1, allow_in=0 -> allowin_out=0 same cycle; allow_in=1 with valid_in=1, data 0x5 -> allowin_out=1 same cycle, data_out=0x5 next.
REQ-034 occupancy 2, flush=1 with valid_in=1 data 0x77 -> next cycle valid_out=0, occupancy 0, 0x77 never appears.
REQ-035 hold valid_out=1, allow_in=0 for 70000 cycles -> stall_cnt=0xFFFF, no wrap; rsta pulse -> stall_cnt=0 asynchronously.
REQ-036 assert rsta mid-cycle with occupancy 2 -> valid_out=0, data_out=RST_VAL before next clk edge.
